// File: rtl/i_cache_refill_ctrl.sv
// I-cache refill controller: miss capture, line refill, FIFO-order victim selection, flush sequencing.
// Define ICACHE_MISS_CNT_EN to build the saturating refill counter behind miss_count.
module i_cache_refill_ctrl #(
  parameter int NUM_LINES = 8,
  parameter int LINE_W    = 128,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  input  logic              hit,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req_valid,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [27:0]       fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              valid_clr_all,
  output logic [31:0]       miss_count,
  output logic [2:0]        state_dbg
);

  // mem_req: a request transfers on a rising edge where mem_req_valid & mem_req_ready;
  // valid and addr stay stable until then. mem_rsp has no ready and is only taken in WAIT.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FILL  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [31:0]       miss_addr;
  logic [IDX_W-1:0]  victim;
  logic              flush_pend;
  logic              miss_take;
  logic              pc_offset_unused;

  assign pc_offset_unused = ^lookup_pc[3:0];
  assign miss_take        = (state == IDLE) && lookup_valid && !hit && !flush;
  assign mem_req_addr     = miss_addr;
  assign state_dbg        = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    valid_clr_all = 1'b0;
    case (state)
      IDLE: begin
        if (flush)                     state_next = FLUSH;
        else if (lookup_valid && !hit) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_next = FILL;
      end
      FILL: begin
        fill_we    = 1'b1;
        state_next = (flush_pend || flush) ? FLUSH : IDLE;
      end
      FLUSH: begin
        valid_clr_all = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // stall is forced low while reset is held so the core never sees a spurious hold.
  assign stall = rst & ((state != IDLE) | (lookup_valid & ~hit) | flush | flush_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_addr  <= '0;
      victim     <= '0;
      flush_pend <= 1'b0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      fill_data  <= '0;
    end else begin
      if (miss_take) miss_addr <= {lookup_pc[31:4], 4'b0000};
      // Fill port registers load on response so they hold between fills.
      if (state == WAIT && mem_rsp_valid) begin
        fill_data <= mem_rsp_data;
        fill_idx  <= victim;
        fill_tag  <= miss_addr[31:4];
      end
      if (state == FILL)       victim <= victim + IDX_W'(1);
      else if (state == FLUSH) victim <= '0;
      if (state == FLUSH)                  flush_pend <= 1'b0;
      else if (flush && state != IDLE)     flush_pend <= 1'b1;
    end
  end

`ifdef ICACHE_MISS_CNT_EN
  logic [31:0] miss_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     miss_cnt_q <= '0;
    else if (state == FILL && miss_cnt_q != '1)   miss_cnt_q <= miss_cnt_q + 32'd1;
  end
  assign miss_count = miss_cnt_q;
`else
  assign miss_count = '0;
`endif

endmodule
